// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field layout, opcode constants used by
// the controller, and the fetch-stage state encoding.
package cpu_pkg;

    localparam int INSTR_W = 8;

    // Instruction fields: [7:4] opcode, [3:0] operand
    localparam int OPC_MSB = 7;
    localparam int OPC_LSB = 4;
    localparam int OPR_MSB = 3;
    localparam int OPR_LSB = 0;
    localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;
    localparam int OPR_W   = OPR_MSB - OPR_LSB + 1;

    localparam logic [OPC_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OPC_W-1:0] OP_ADD  = 4'h1;
    localparam logic [OPC_W-1:0] OP_SUB  = 4'h2;
    localparam logic [OPC_W-1:0] OP_AND  = 4'h3;
    localparam logic [OPC_W-1:0] OP_OR   = 4'h4;
    localparam logic [OPC_W-1:0] OP_XOR  = 4'h5;
    localparam logic [OPC_W-1:0] OP_LDI  = 4'h6;
    localparam logic [OPC_W-1:0] OP_MOV  = 4'h7;
    localparam logic [OPC_W-1:0] OP_JMP  = 4'h8;
    localparam logic [OPC_W-1:0] OP_JR   = 4'h9;
    localparam logic [OPC_W-1:0] OP_BZ   = 4'hA;
    localparam logic [OPC_W-1:0] OP_HALT = 4'hF;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_EXEC  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC selection.
//   pc       : current program counter
//   operand  : 4-bit immediate, sign-extended for PC-relative jumps
//   jmp_reg  : absolute jump target from the register file
//   inc_pc   : advance to pc+1
//   load_pc  : take a jump (priority over inc_pc)
//   sel_pc   : jump source, 1 = pc + imm, 0 = jmp_reg
//   next_pc  : selected PC; all arithmetic wraps modulo 2^PC_W
module pc_next
    import cpu_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic [PC_W-1:0]  pc,
    input  logic [OPR_W-1:0] operand,
    input  logic [PC_W-1:0]  jmp_reg,
    input  logic             inc_pc,
    input  logic             load_pc,
    input  logic             sel_pc,
    output logic [PC_W-1:0]  next_pc
);

    logic [PC_W-1:0] imm_ext;

    assign imm_ext = PC_W'($signed(operand));

    always_comb begin
        next_pc = pc;
        if (load_pc) begin
            next_pc = sel_pc ? (pc + imm_ext) : jmp_reg;
        end else if (inc_pc) begin
            next_pc = pc + PC_W'(1);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns PC and IR, fetches one instruction per step
// over a req/ack handshake and applies the controller's PC decisions.
//   Clk, Rst            : clock, synchronous active-high reset
//   IMemAddr/IMemReq    : fetch address (= Pc) and request
//   IMemAck/IMemData    : memory response
//   Opcode/Operand      : IR fields to the controller
//   InstrValid          : high for every EXEC cycle
//   Halted              : EXEC with a HALT opcode
//   LoadIR/IncPC/LoadPC/SelPC/JmpReg : controller next-PC controls
//   Pc                  : current PC for trace
module instr_fetch_unit #(
    parameter int                PC_W     = 8,
    parameter int                INSTR_W  = cpu_pkg::INSTR_W,
    parameter logic [PC_W-1:0]   RESET_PC = '0
) (
    input  logic                       Clk,
    input  logic                       Rst,
    output logic [PC_W-1:0]            IMemAddr,
    output logic                       IMemReq,
    input  logic                       IMemAck,
    input  logic [INSTR_W-1:0]         IMemData,
    output logic [cpu_pkg::OPC_W-1:0]  Opcode,
    output logic [cpu_pkg::OPR_W-1:0]  Operand,
    output logic                       InstrValid,
    output logic                       Halted,
    input  logic                       LoadIR,
    input  logic                       IncPC,
    input  logic                       LoadPC,
    input  logic                       SelPC,
    input  logic [PC_W-1:0]            JmpReg,
    output logic [PC_W-1:0]            Pc
);

    import cpu_pkg::*;

    fetch_state_e         state_q, state_d;
    logic [PC_W-1:0]      pc_q, pc_d, pc_nxt;
    logic [INSTR_W-1:0]   ir_q, ir_d;

    pc_next #(.PC_W(PC_W)) u_pc_next (
        .pc      (pc_q),
        .operand (ir_q[OPR_MSB:OPR_LSB]),
        .jmp_reg (JmpReg),
        .inc_pc  (IncPC),
        .load_pc (LoadPC),
        .sel_pc  (SelPC),
        .next_pc (pc_nxt)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            ST_FETCH, ST_WAIT: begin
                if (IMemAck) begin
                    ir_d    = IMemData;
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_EXEC: begin
                // LoadIR low is the stall/HALT hold: PC and IR frozen
                if (LoadIR) begin
                    pc_d    = pc_nxt;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Request is suppressed while reset is held so an abandoned fetch is
    // visible to memory in the same cycle reset asserts.
    assign IMemReq    = (state_q != ST_EXEC) && !Rst;
    assign IMemAddr   = pc_q;
    assign Pc         = pc_q;
    assign Opcode     = ir_q[OPC_MSB:OPC_LSB];
    assign Operand    = ir_q[OPR_MSB:OPR_LSB];
    assign InstrValid = (state_q == ST_EXEC);
    assign Halted     = InstrValid && (Opcode == OP_HALT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    logic       Clk = 1'b0;
    logic       Rst;
    logic [7:0] IMemAddr;
    logic       IMemReq;
    logic       IMemAck;
    logic [7:0] IMemData;
    logic [3:0] Opcode;
    logic [3:0] Operand;
    logic       InstrValid;
    logic       Halted;
    logic       LoadIR;
    logic       IncPC;
    logic       LoadPC;
    logic       SelPC;
    logic [7:0] JmpReg;
    logic [7:0] Pc;

    int checks = 0;
    int errors = 0;

    instr_fetch_unit #(.PC_W(8), .INSTR_W(8), .RESET_PC(8'h00)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .IMemAddr   (IMemAddr),
        .IMemReq    (IMemReq),
        .IMemAck    (IMemAck),
        .IMemData   (IMemData),
        .Opcode     (Opcode),
        .Operand    (Operand),
        .InstrValid (InstrValid),
        .Halted     (Halted),
        .LoadIR     (LoadIR),
        .IncPC      (IncPC),
        .LoadPC     (LoadPC),
        .SelPC      (SelPC),
        .JmpReg     (JmpReg),
        .Pc         (Pc)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Abstract view: either "waiting for an instruction" or "holding one".
    logic [7:0] m_pc, m_ir;
    bit         m_exec;
    bit         m_init = 1'b0;

    function automatic logic [7:0] model_next(input logic [7:0] pc, input logic [3:0] imm,
                                              input logic [7:0] jr, input logic inc,
                                              input logic ldpc, input logic sel);
        int t, off;
        if (ldpc && sel) begin
            off = int'(imm);
            if (off > 7) off = off - 16;
            t = (int'(pc) + off + 256) % 256;
        end else if (ldpc) begin
            t = int'(jr);
        end else if (inc) begin
            t = (int'(pc) + 1) % 256;
        end else begin
            t = int'(pc);
        end
        return t[7:0];
    endfunction

    always @(posedge Clk) begin
        if (Rst) begin
            m_pc   <= 8'h00;
            m_ir   <= 8'h00;
            m_exec <= 1'b0;
            m_init <= 1'b1;
        end else if (m_init) begin
            if (!m_exec) begin
                if (IMemAck) begin
                    m_ir   <= IMemData;
                    m_exec <= 1'b1;
                end
            end else if (LoadIR) begin
                m_pc   <= model_next(m_pc, m_ir[3:0], JmpReg, IncPC, LoadPC, SelPC);
                m_exec <= 1'b0;
            end
        end
    end

    always @(negedge Clk) begin
        if (m_init) begin
            chk("m_req",     IMemReq,    32'(!m_exec && !Rst));
            chk("m_addr",    IMemAddr,   m_pc);
            chk("m_pc",      Pc,         m_pc);
            chk("m_opcode",  Opcode,     m_ir[7:4]);
            chk("m_operand", Operand,    m_ir[3:0]);
            chk("m_valid",   InstrValid, 32'(m_exec));
            chk("m_halted",  Halted,     32'(m_exec && m_ir[7:4] == 4'hF));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    task automatic fetch(input logic [7:0] d);
        IMemAck  = 1'b1;
        IMemData = d;
        tick();
        IMemAck  = 1'b0;
    endtask

    task automatic exec(input logic ldir, input logic inc, input logic ldpc,
                        input logic sel, input logic [7:0] jr);
        LoadIR = ldir; IncPC = inc; LoadPC = ldpc; SelPC = sel; JmpReg = jr;
        tick();
        LoadIR = 1'b0; IncPC = 1'b0; LoadPC = 1'b0; SelPC = 1'b0;
    endtask

    initial begin
        Rst = 1'b1; IMemAck = 1'b0; IMemData = 8'h00;
        LoadIR = 1'b0; IncPC = 1'b0; LoadPC = 1'b0; SelPC = 1'b0; JmpReg = 8'h00;
        tick(); tick();
        chk("rst_pc",     Pc, 8'h00);
        chk("rst_req",    IMemReq, 0);
        chk("rst_valid",  InstrValid, 0);
        chk("rst_halted", Halted, 0);
        chk("rst_opcode", Opcode, 0);

        // First instruction, same-cycle ack
        Rst = 1'b0; IMemAck = 1'b1; IMemData = 8'h1A; LoadIR = 1'b1; IncPC = 1'b1;
        #1;
        chk("first_req",  IMemReq, 1);
        chk("first_addr", IMemAddr, 8'h00);
        tick();
        chk("i1_opcode",  Opcode, 4'h1);
        chk("i1_operand", Operand, 4'hA);
        chk("i1_valid",   InstrValid, 1);
        IMemAck = 1'b0;
        tick();
        chk("i1_next_pc", Pc, 8'h01);
        chk("i1_next_req", IMemReq, 1);
        LoadIR = 1'b0; IncPC = 1'b0;

        // Ack delayed three cycles; data bus noise must not reach IR
        IMemData = 8'h55;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin IMemAck = 1'b1; IMemData = 8'h7E; end
            #1;
            chk("wait_req",    IMemReq, 1);
            chk("wait_addr",   IMemAddr, 8'h01);
            chk("wait_valid",  InstrValid, 0);
            chk("wait_opcode", Opcode, 4'h1);
            tick();
        end
        IMemAck = 1'b0;
        chk("wait_exec_valid", InstrValid, 1);
        chk("wait_exec_ir",    {Opcode, Operand}, 8'h7E);

        exec(1, 0, 1, 0, 8'h10);
        chk("jreg_10", Pc, 8'h10);
        fetch(8'h7E);
        exec(1, 1, 1, 1, 8'h00);          // jump beats increment: 0x10 + (-2)
        chk("rel_0e", Pc, 8'h0E);
        fetch(8'h70);
        exec(1, 0, 1, 0, 8'h42);
        chk("jreg_42", Pc, 8'h42);
        fetch(8'h00);
        exec(1, 0, 1, 0, 8'hFF);
        chk("jreg_ff", Pc, 8'hFF);
        fetch(8'h00);
        exec(1, 1, 0, 0, 8'h00);
        chk("inc_wrap", Pc, 8'h00);
        fetch(8'h00);
        exec(1, 0, 1, 0, 8'h02);
        fetch(8'h8C);
        exec(1, 0, 1, 1, 8'h00);          // 0x02 + (-4)
        chk("rel_wrap", Pc, 8'hFE);
        fetch(8'h00);
        exec(1, 0, 0, 0, 8'h00);          // no inc, no jump: refetch same address
        chk("refetch_pc",  Pc, 8'hFE);
        chk("refetch_req", IMemReq, 1);

        // HALT residency with distracting controls and ack
        fetch(8'hF0);
        LoadIR = 1'b0; LoadPC = 1'b1; IncPC = 1'b1; IMemAck = 1'b1; IMemData = 8'h33;
        for (int i = 0; i < 10; i++) begin
            chk("halt_halted", Halted, 1);
            chk("halt_valid",  InstrValid, 1);
            chk("halt_req",    IMemReq, 0);
            chk("halt_pc",     Pc, 8'hFE);
            chk("halt_opcode", Opcode, 4'hF);
            tick();
        end
        IMemAck = 1'b0; LoadPC = 1'b0; IncPC = 1'b0;
        exec(1, 1, 0, 0, 8'h00);
        chk("post_halt_pc", Pc, 8'hFF);

        // Reset during WAIT with an ack landing in the same cycle
        tick();
        chk("rw_wait_req",   IMemReq, 1);
        chk("rw_wait_valid", InstrValid, 0);
        Rst = 1'b1; IMemAck = 1'b1; IMemData = 8'h9C;
        #1;
        chk("rw_req_in_rst", IMemReq, 0);
        tick();
        Rst = 1'b0; IMemAck = 1'b0;
        #1;
        chk("rw_pc",    Pc, 8'h00);
        chk("rw_ir",    {Opcode, Operand}, 8'h00);
        chk("rw_req",   IMemReq, 1);
        chk("rw_valid", InstrValid, 0);
        tick();
        fetch(8'h12);
        chk("rw_refetch_ir", {Opcode, Operand}, 8'h12);

        // Reset during EXEC discards the pending jump
        Rst = 1'b1; LoadIR = 1'b1; LoadPC = 1'b1; SelPC = 1'b0; JmpReg = 8'h80;
        tick();
        Rst = 1'b0; LoadIR = 1'b0; LoadPC = 1'b0;
        #1;
        chk("re_pc",    Pc, 8'h00);
        chk("re_valid", InstrValid, 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
